// File: rtl/stat_scheduler_if.sv
// -----------------------------------------------------------------------------
// stat_scheduler_if
//   Address/strobe port between the stat scheduler and the pet-status
//   register bank.
//
//   state       bank address, driven by the scheduler
//   UpState     one-cycle increment strobe for the entry at state
//   DownState   one-cycle decrement strobe for the entry at state
//   stateValue  bank read data for the entry at state
//
//   master: scheduler side; slave: bank side.
// -----------------------------------------------------------------------------
interface stat_scheduler_if #(
    parameter int BIT_ADDR = 3,
    parameter int BIT_DATO = 3
);
    logic [BIT_ADDR-1:0] state;
    logic                UpState;
    logic                DownState;
    logic [BIT_DATO-1:0] stateValue;

    modport master (
        output state,
        output UpState,
        output DownState,
        input  stateValue
    );

    modport slave (
        input  state,
        input  UpState,
        input  DownState,
        output stateValue
    );
endinterface

// File: rtl/stat_scheduler.sv
// -----------------------------------------------------------------------------
// stat_scheduler
//   Shares the status bank's single address/strobe port between user action
//   requests (increment entries 0..3) and a periodic decay sweep (decrement
//   entries 0..NSTAT-1). After each sweep the health entry is read back and a
//   sticky death flag is raised if it reached DEAD_VAL.
//
//   clk    system clock, rising edge
//   Reset  asynchronous active-low reset
//   req    action request pulses, bit i increments entry i
//   bank   address/strobe port to the status bank (master side)
//   busy   high while an access or a sweep is in progress
//   dead   sticky death flag, cleared only by Reset
//   tick   one-cycle pulse at each decay tick
// -----------------------------------------------------------------------------
module stat_scheduler #(
    parameter int BIT_ADDR    = 3,
    parameter int BIT_DATO    = 3,
    parameter int NSTAT       = 5,
    parameter int TICK_DIV    = 50000000,
    parameter int HEALTH_ADDR = 4,
    parameter int DEAD_VAL    = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [3:0]            req,
    stat_scheduler_if.master      bank,
    output logic                  busy,
    output logic                  dead,
    output logic                  tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [BIT_ADDR-1:0] SWEEP_END = BIT_ADDR'(NSTAT - 1);
    localparam logic [BIT_ADDR-1:0] HEALTH_A  = BIT_ADDR'(HEALTH_ADDR);
    localparam logic [BIT_DATO-1:0] DEAD_V    = BIT_DATO'(DEAD_VAL);

    typedef enum logic [2:0] {
        IDLE,
        U_ADDR,
        U_STB,
        D_ADDR,
        D_STB,
        CHK
    } fsm_e;

    fsm_e                fsm_q,   fsm_d;
    logic [BIT_ADDR-1:0] addr_q,  addr_d;
    logic [3:0]          pend_q,  pend_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                dpend_q, dpend_d;
    logic                dead_q,  dead_d;
    logic                up_q,    up_d;
    logic                down_q,  down_d;
    logic                busy_q,  busy_d;

    logic [3:0]          pend_clr;
    logic                take_decay;

    // Lowest set bit wins, so feed beats play beats sleep beats heal.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        fsm_d      = fsm_q;
        addr_d     = addr_q;
        dead_d     = dead_q;
        pend_clr   = 4'b0000;
        take_decay = 1'b0;

        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        unique case (fsm_q)
            IDLE: begin
                if (!dead_q) begin
                    if (|pend_q) begin
                        addr_d = BIT_ADDR'(lowest_set(pend_q));
                        fsm_d  = U_ADDR;
                    end else if (dpend_q) begin
                        addr_d     = '0;
                        take_decay = 1'b1;
                        fsm_d      = D_ADDR;
                    end
                end
            end
            U_ADDR: fsm_d = U_STB;
            U_STB: begin
                pend_clr = 4'b0001 << addr_q[1:0];
                fsm_d    = IDLE;
            end
            D_ADDR: fsm_d = D_STB;
            D_STB: begin
                if (addr_q == SWEEP_END) begin
                    addr_d = HEALTH_A;
                    fsm_d  = CHK;
                end else begin
                    addr_d = addr_q + BIT_ADDR'(1);
                    fsm_d  = D_ADDR;
                end
            end
            CHK: begin
                // Bank already applied the last decrement, so this is the
                // post-decay health value.
                if (bank.stateValue == DEAD_V) dead_d = 1'b1;
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        // A request landing on the clearing cycle re-sets its bit.
        pend_d = (pend_q & ~pend_clr) | req;

        // Ticks while a sweep is already pending simply merge into it.
        if (take_decay)  dpend_d = 1'b0;
        else if (tick)   dpend_d = 1'b1;
        else             dpend_d = dpend_q;

        // Outputs are decoded from the next state and registered, so they
        // line up with the state the FSM is in.
        up_d   = (fsm_d == U_STB);
        down_d = (fsm_d == D_STB);
        busy_d = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            fsm_q   <= IDLE;
            addr_q  <= '0;
            pend_q  <= 4'b0000;
            cnt_q   <= '0;
            dpend_q <= 1'b0;
            dead_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // pre-edge values, independent of statement order.
            fsm_q   <= fsm_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            dpend_q <= dpend_d;
            dead_q  <= dead_d;
            up_q    <= up_d;
            down_q  <= down_d;
            busy_q  <= busy_d;
        end
    end

    assign bank.state     = addr_q;
    assign bank.UpState   = up_q;
    assign bank.DownState = down_q;
    assign busy           = busy_q;
    assign dead           = dead_q;

endmodule

// File: tb/tb_stat_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stat_scheduler
//   Directed bench for stat_scheduler with TICK_DIV=16. A small clamping
//   status bank (values 1..5) answers the scheduler's port. Cycle numbers in
//   the comments count rising edges since Reset was released; cycle 0 is the
//   period right after release, tick fires in cycle 15.
// -----------------------------------------------------------------------------
module tb_stat_scheduler;

    localparam int BIT_ADDR = 3;
    localparam int BIT_DATO = 3;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       busy, dead, tick;

    stat_scheduler_if #(.BIT_ADDR(BIT_ADDR), .BIT_DATO(BIT_DATO)) bank_if ();

    stat_scheduler #(
        .BIT_ADDR   (BIT_ADDR),
        .BIT_DATO   (BIT_DATO),
        .NSTAT      (5),
        .TICK_DIV   (16),
        .HEALTH_ADDR(4),
        .DEAD_VAL   (1)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .req  (req),
        .bank (bank_if.master),
        .busy (busy),
        .dead (dead),
        .tick (tick)
    );

    always #5 clk = ~clk;

    // Status bank model: clamps to 1..5, loadable for test setup.
    logic [BIT_DATO-1:0] mem [8];
    logic [BIT_DATO-1:0] load_val [8];
    logic                load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[i] <= load_val[i];
        end else if (bank_if.UpState) begin
            if (mem[bank_if.state] < 3'd5) mem[bank_if.state] <= mem[bank_if.state] + 3'd1;
        end else if (bank_if.DownState) begin
            if (mem[bank_if.state] > 3'd1) mem[bank_if.state] <= mem[bank_if.state] - 3'd1;
        end
    end

    assign bank_if.stateValue = mem[bank_if.state];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) adv(1);
    endtask

    task automatic preload(input logic [2:0] v, input logic [2:0] v2, input logic [2:0] v4);
        for (int i = 0; i < 8; i++) load_val[i] = v;
        load_val[2] = v2;
        load_val[4] = v4;
    endtask

    // Reset for two edges while loading the bank, release just after an edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        Reset = 1'b0;
        req   = 4'b0000;
        load  = 1'b1;
        adv(2);
        load  = 1'b0;
        Reset = 1'b1;
        cyc   = 0;
    endtask

    int n_up, n_down, n_busy, n_tick;
    int down_addr [8];

    initial begin
        // ---------------- reset state ----------------
        #3 Reset = 1'b0;
        #1;
        check("rst_state", bank_if.state, 0);
        check("rst_up",    bank_if.UpState, 0);
        check("rst_down",  bank_if.DownState, 0);
        check("rst_busy",  busy, 0);
        check("rst_dead",  dead, 0);
        check("rst_tick",  tick, 0);

        // ---------------- single request ----------------
        preload(3'd3, 3'd3, 3'd3);
        do_reset();
        req = 4'b0010;
        adv(1);
        req = 4'b0000;
        check("single_c1_busy", busy, 0);
        adv(1);
        check("single_c2_state", bank_if.state, 1);
        check("single_c2_busy",  busy, 1);
        check("single_c2_up",    bank_if.UpState, 0);
        adv(1);
        check("single_c3_state", bank_if.state, 1);
        check("single_c3_busy",  busy, 1);
        check("single_c3_up",    bank_if.UpState, 1);
        check("single_c3_down",  bank_if.DownState, 0);
        adv(1);
        check("single_c4_busy",  busy, 0);
        check("single_c4_up",    bank_if.UpState, 0);
        check("single_bank1",    mem[1], 4);

        // ---------------- simultaneous requests ----------------
        req = 4'b1001;
        adv(1);
        req = 4'b0000;
        n_up = 0;
        while (cyc < 15) begin
            if (bank_if.UpState) n_up++;
            if (cyc == 6) check("simul_c6_state", bank_if.state, 0);
            if (cyc == 7) check("simul_c7_up0", {bank_if.UpState, bank_if.state}, {1'b1, 3'd0});
            if (cyc == 8) check("simul_c8_idle", busy, 0);
            if (cyc == 9) check("simul_c9_state", bank_if.state, 3);
            if (cyc == 10) check("simul_c10_up3", {bank_if.UpState, bank_if.state}, {1'b1, 3'd3});
            adv(1);
        end
        check("simul_up_count", n_up, 2);
        check("simul_bank0", mem[0], 4);
        check("simul_bank3", mem[3], 4);

        // ---------------- decay sweep ----------------
        check("sweep_tick_c15", tick, 1);
        adv(1);
        check("sweep_tick_c16", tick, 0);
        n_up = 0; n_down = 0; n_busy = 0;
        while (cyc <= 29) begin
            if (busy) n_busy++;
            if (bank_if.UpState) n_up++;
            if (bank_if.DownState) begin
                if (n_down < 8) down_addr[n_down] = int'(bank_if.state);
                n_down++;
            end
            if (cyc == 27) begin
                check("sweep_chk_state", bank_if.state, 4);
                check("sweep_chk_busy",  busy, 1);
                check("sweep_chk_down",  bank_if.DownState, 0);
            end
            adv(1);
        end
        check("sweep_busy_cycles", n_busy, 11);
        check("sweep_up_count",    n_up, 0);
        check("sweep_down_count",  n_down, 5);
        for (int i = 0; i < 5; i++) check($sformatf("sweep_down_addr%0d", i), down_addr[i], i);
        check("sweep_health", mem[4], 2);
        check("sweep_alive",  dead, 0);

        // ---------------- request during sweep ----------------
        preload(3'd5, 3'd3, 3'd5);
        do_reset();
        go_to(20);
        check("dsw_2nd_down", {bank_if.DownState, bank_if.state}, {1'b1, 3'd1});
        req = 4'b0100;
        adv(1);
        req = 4'b0000;
        n_up = 0; n_down = 0;
        while (cyc < 30) begin
            if (bank_if.UpState) n_up++;
            if (bank_if.DownState) n_down++;
            adv(1);
        end
        check("dsw_up_in_sweep",   n_up, 0);
        check("dsw_down_rest",     n_down, 3);
        check("dsw_up_after",      {bank_if.UpState, bank_if.state}, {1'b1, 3'd2});
        adv(1);
        check("dsw_bank2", mem[2], 3);
        n_up = 0;
        while (cyc <= 45) begin
            if (bank_if.UpState) n_up++;
            adv(1);
        end
        check("dsw_pend2_cleared", n_up, 0);

        // ---------------- death ----------------
        preload(3'd3, 3'd3, 3'd2);
        do_reset();
        go_to(27);
        check("death_chk_state", bank_if.state, 4);
        check("death_chk_value", bank_if.stateValue, 1);
        check("death_chk_dead",  dead, 0);
        adv(1);
        check("death_dead",      dead, 1);
        check("death_idle",      busy, 0);
        req = 4'b1111;
        adv(1);
        req = 4'b0000;
        n_up = 0; n_down = 0; n_busy = 0; n_tick = 0;
        while (cyc <= 70) begin
            if (bank_if.UpState) n_up++;
            if (bank_if.DownState) n_down++;
            if (busy) n_busy++;
            if (tick) n_tick++;
            adv(1);
        end
        check("death_no_up",    n_up, 0);
        check("death_no_down",  n_down, 0);
        check("death_no_busy",  n_busy, 0);
        check("death_ticks",    n_tick, 3);
        check("death_sticky",   dead, 1);

        // ---------------- async reset mid-sweep ----------------
        preload(3'd5, 3'd5, 3'd5);
        do_reset();
        go_to(21);
        check("areset_pre_busy", busy, 1);
        Reset = 1'b0;
        #1;
        check("areset_state", bank_if.state, 0);
        check("areset_up",    bank_if.UpState, 0);
        check("areset_down",  bank_if.DownState, 0);
        check("areset_busy",  busy, 0);
        check("areset_dead",  dead, 0);
        @(posedge clk);
        #1;
        check("areset_hold_down", bank_if.DownState, 0);
        Reset = 1'b1;
        cyc   = 0;
        check("areset_bank1", mem[1], 4);
        check("areset_bank2", mem[2], 5);
        n_up = 0; n_down = 0; n_tick = 0;
        while (cyc < 18) begin
            if (bank_if.UpState) n_up++;
            if (bank_if.DownState) n_down++;
            if (tick) begin
                n_tick++;
                check("areset_tick_cycle", cyc, 15);
            end
            adv(1);
        end
        check("areset_quiet", n_up + n_down, 0);
        check("areset_one_tick", n_tick, 1);
        check("areset_first_down", {bank_if.DownState, bank_if.state}, {1'b1, 3'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stat_scheduler.md
Name: stat_scheduler

Overview:
- Sequencer and arbiter for the 8-entry pet-status register bank.
- Shares the bank's single address/strobe port between two sources:
  - user action requests: feed, play, sleep, heal, which raise stats 0..3;
  - a periodic decay timer, which lowers stats 0..NSTAT-1.
- After every decay sweep it reads the health entry and raises a sticky death flag.
- Sits between the button debouncers and the status bank; feeds the display FSM.

Parameters:
- BIT_ADDR, 3, bank address width.
- BIT_DATO, 3, bank data width.
- NSTAT, 5, number of entries decayed per sweep (addresses 0..NSTAT-1); must be ≤ 2**BIT_ADDR.
- TICK_DIV, 50000000, clk cycles between decay ticks; minimum 4.
- HEALTH_ADDR, 4, address checked for death.
- DEAD_VAL, 1, health value that means dead.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  4  action request pulses; bit i requests an increment of address i (0 feed, 1 play, 2 sleep, 3 heal).
- stateValue  in  BIT_DATO  bank read data for the address on state.
- state  out  BIT_ADDR  bank address.
- UpState  out  1  one-cycle increment strobe.
- DownState  out  1  one-cycle decrement strobe.
- busy  out  1  high while an access or a sweep is in progress.
- dead  out  1  sticky death flag.
- tick  out  1  one-cycle pulse at each decay tick, for observation.

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0, state=0, FSM in IDLE, pending requests cleared, tick counter 0, decay_pending=0.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps;
  - tick=1 in the cycle the count equals TICK_DIV-1;
  - a tick sets decay_pending;
  - ticks arriving while decay_pending=1 coalesce and are not counted.
- Request capture:
  - req[i]=1 on any cycle sets pend[i];
  - pend[i] clears in the cycle its strobe is issued;
  - a req[i] arriving in the same cycle as pend[i] clears leaves pend[i]=1, so the request is not lost.
- FSM states: IDLE, U_ADDR, U_STB, D_ADDR, D_STB, CHK.
- IDLE:
  - if dead: stay; no strobes; pend ignored.
  - else if any pend: latch the lowest set index k, state=k, go to U_ADDR. User actions have priority over decay.
  - else if decay_pending: idx=0, state=0, clear decay_pending, go to D_ADDR.
  - busy=0 only in IDLE.
- U_ADDR: hold state=k, strobes 0 (address setup cycle); go to U_STB.
- U_STB: UpState=1 for exactly this cycle, state=k, clear pend[k]; go to IDLE.
- D_ADDR: state=idx, strobes 0; go to D_STB.
- D_STB:
  - DownState=1 for exactly this cycle.
  - If idx=NSTAT-1: state=HEALTH_ADDR next, go to CHK.
  - Else: idx+1, go to D_ADDR.
  - A sweep is not interruptible by requests; they stay pending.
- CHK:
  - state=HEALTH_ADDR, strobes 0; sample stateValue (this is the post-decrement value);
  - if stateValue==DEAD_VAL, set dead;
  - go to IDLE.
- Timing and exclusivity:
  - UpState and DownState are never high in the same cycle.
  - Each strobe is preceded by at least one cycle with state stable.
- Costs:
  - user access: 2 cycles;
  - full sweep: 2*NSTAT+1 cycles (11 at default).
- Clamping (values 1..5) is done by the bank. The controller issues strobes regardless of value.
- dead:
  - stays 1 until Reset;
  - the tick counter keeps running while dead, but decay_pending is ignored.
- Reset mid-sweep or mid-access aborts immediately; no strobe is emitted after Reset falls.
- After Reset releases, the first tick comes TICK_DIV cycles later.

Test Plan:
- Single request: TICK_DIV=16, pulse req=4'b0010 → state=1 for 2 cycles, UpState=1 on the 2nd cycle only, busy=1 for 2 cycles; bank entry 1 goes from 3 to 4.
- Simultaneous requests: req=4'b1001 in one cycle → serviced as address 0 then address 3, back-to-back with an IDLE cycle between; exactly two UpState pulses.
- Decay sweep: TICK_DIV=16, no requests → tick at cycle 15; DownState pulses on addresses 0,1,2,3,4 in that order; CHK reads address 4; 11 busy cycles; no UpState.
- Request during sweep: req[2] pulsed at the 2nd DownState → sweep completes untouched, then address 2 is incremented; pend[2] is then 0.
- Death: health preloaded to 2, one tick → DownState on address 4, CHK sees 1, dead=1; later req=4'b1111 and further ticks produce no strobes.
- Async reset mid-sweep: Reset=0 between the 2nd and 3rd DownState → state, UpState, DownState, busy and dead all 0 immediately; after release, no strobe until the next request or a tick 16 cycles later.
